pipe_bundle_reg: RTL and testbench

PIPE_BUNDLE_REG -- requirements
Module: pipe_bundle_reg

---
 rtl/pipe_bundle_reg_pkg.sv | 26 ++
 rtl/pipe_bundle_reg_slot.sv | 60 ++++++
 rtl/pipe_bundle_reg.sv | 156 +++++++++++++++
 tb/tb_pipe_bundle_reg.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_bundle_reg_pkg.sv
// Shared definitions for the bundle pipeline register: occupancy state
// encoding and default geometry.
package pipe_bundle_reg_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  localparam int DEF_LANES = 2;
  localparam int DEF_PW    = 128;

  // Number of held bundles for a given state.
  function automatic logic [1:0] state_occupancy(input state_e s);
    logic [1:0] occ;
    case (s)
      ST_EMPTY: occ = 2'd0;
      ST_ONE:   occ = 2'd1;
      ST_TWO:   occ = 2'd2;
      default:  occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/pipe_bundle_reg_slot.sv
// One bundle storage slot: per-lane valid plus payload, with whole-slot clear,
// load (invalid lanes stored as zero) and per-lane clear.
module bundle_slot
  import pipe_bundle_reg_pkg::*;
#(
  parameter int LANES = DEF_LANES,
  parameter int PW    = DEF_PW
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_clr,
  input  logic                  i_load,
  input  logic [LANES-1:0]      i_ld_valid,
  input  logic [LANES*PW-1:0]   i_ld_payload,
  input  logic [LANES-1:0]      i_lane_clr,
  output logic [LANES-1:0]      o_valid,
  output logic [LANES*PW-1:0]   o_payload
);

  logic [LANES-1:0]    r_valid;
  logic [LANES*PW-1:0] r_payload;
  logic [LANES*PW-1:0] w_ld_masked;
  logic [LANES*PW-1:0] w_lane_cleared;

  // Zero the payload of invalid incoming lanes and of lanes being killed.
  always_comb begin
    w_ld_masked    = i_ld_payload;
    w_lane_cleared = r_payload;
    for (int i = 0; i < LANES; i++) begin
      if (!i_ld_valid[i]) begin
        w_ld_masked[i*PW +: PW] = {PW{1'b0}};
      end else begin
        w_ld_masked[i*PW +: PW] = i_ld_payload[i*PW +: PW];
      end
      if (i_lane_clr[i]) begin
        w_lane_cleared[i*PW +: PW] = {PW{1'b0}};
      end else begin
        w_lane_cleared[i*PW +: PW] = r_payload[i*PW +: PW];
      end
    end
  end

  // Slot storage: reset/clear beat load, load beats lane-clear.
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_valid   <= {LANES{1'b0}};
      r_payload <= {(LANES*PW){1'b0}};
    end else if (i_load) begin
      r_valid   <= i_ld_valid;
      r_payload <= w_ld_masked;
    end else begin
      r_valid   <= r_valid & ~i_lane_clr;
      r_payload <= w_lane_cleared;
    end
  end

  assign o_valid   = r_valid;
  assign o_payload = r_payload;

endmodule

// File: rtl/pipe_bundle_reg.sv
// Two-deep bundle pipeline register (MAIN + SKID) with flush and per-lane
// kill; in_ready and occupancy come straight from registers.
module pipe_bundle_reg
  import pipe_bundle_reg_pkg::*;
#(
  parameter int LANES = DEF_LANES,
  parameter int PW    = DEF_PW
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [LANES-1:0]      kill,
  input  logic [LANES-1:0]      in_valid,
  input  logic [LANES*PW-1:0]   in_payload,
  output logic                  in_ready,
  output logic [LANES-1:0]      out_valid,
  output logic [LANES*PW-1:0]   out_payload,
  input  logic                  out_ready,
  output logic [1:0]            occupancy
);

  state_e              r_state;
  state_e              w_state_nxt;
  logic                r_in_ready;
  logic [1:0]          r_occupancy;

  logic [LANES-1:0]    w_main_valid;
  logic [LANES*PW-1:0] w_main_payload;
  logic [LANES-1:0]    w_skid_valid;
  logic [LANES*PW-1:0] w_skid_payload;

  logic                w_accept;
  logic                w_consume;
  logic                w_kill_empties;
  logic                w_pop;
  logic [LANES-1:0]    w_kill_clr;

  logic                w_main_load;
  logic                w_main_src_skid;
  logic                w_main_clr;
  logic [LANES-1:0]    w_main_lane_clr;
  logic                w_skid_load;
  logic                w_skid_clr;
  logic [LANES-1:0]    w_main_ld_valid;
  logic [LANES*PW-1:0] w_main_ld_payload;

  assign w_accept  = (|in_valid) && r_in_ready && !flush;
  assign w_consume = (|w_main_valid) && out_ready;
  // A kill that removes every remaining lane of MAIN retires the bundle.
  assign w_kill_clr     = w_consume ? {LANES{1'b0}} : kill;
  assign w_kill_empties = !w_consume && (|w_main_valid) &&
                          ((w_main_valid & ~kill) == {LANES{1'b0}});
  assign w_pop          = w_consume || w_kill_empties;

  // Next-state and slot control.
  always_comb begin
    w_state_nxt     = r_state;
    w_main_load     = 1'b0;
    w_main_src_skid = 1'b0;
    w_main_clr      = 1'b0;
    w_main_lane_clr = {LANES{1'b0}};
    w_skid_load     = 1'b0;
    w_skid_clr      = 1'b0;
    if (flush) begin
      w_main_clr  = 1'b1;
      w_skid_clr  = 1'b1;
      w_state_nxt = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            w_main_load = 1'b1;
            w_state_nxt = ST_ONE;
          end else begin
            w_state_nxt = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (w_accept && w_pop) begin
            w_main_load = 1'b1;
          end else if (w_accept) begin
            w_skid_load     = 1'b1;
            w_main_lane_clr = w_kill_clr;
            w_state_nxt     = ST_TWO;
          end else if (w_pop) begin
            w_main_clr  = 1'b1;
            w_state_nxt = ST_EMPTY;
          end else begin
            w_main_lane_clr = w_kill_clr;
          end
        end
        ST_TWO: begin
          if (w_pop) begin
            w_main_load     = 1'b1;
            w_main_src_skid = 1'b1;
            w_skid_clr      = 1'b1;
            w_state_nxt     = ST_ONE;
          end else begin
            w_main_lane_clr = w_kill_clr;
          end
        end
        default: begin
          w_main_clr  = 1'b1;
          w_skid_clr  = 1'b1;
          w_state_nxt = ST_EMPTY;
        end
      endcase
    end
  end

  assign w_main_ld_valid   = w_main_src_skid ? w_skid_valid   : in_valid;
  assign w_main_ld_payload = w_main_src_skid ? w_skid_payload : in_payload;

  // State plus the registered ready/occupancy views of it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_EMPTY;
      r_in_ready  <= 1'b1;
      r_occupancy <= 2'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt != ST_TWO);
      r_occupancy <= state_occupancy(w_state_nxt);
    end
  end

  bundle_slot #(.LANES(LANES), .PW(PW)) u_main (
    .clk          (clk),
    .rst          (rst),
    .i_clr        (w_main_clr),
    .i_load       (w_main_load),
    .i_ld_valid   (w_main_ld_valid),
    .i_ld_payload (w_main_ld_payload),
    .i_lane_clr   (w_main_lane_clr),
    .o_valid      (w_main_valid),
    .o_payload    (w_main_payload)
  );

  bundle_slot #(.LANES(LANES), .PW(PW)) u_skid (
    .clk          (clk),
    .rst          (rst),
    .i_clr        (w_skid_clr),
    .i_load       (w_skid_load),
    .i_ld_valid   (in_valid),
    .i_ld_payload (in_payload),
    .i_lane_clr   ({LANES{1'b0}}),
    .o_valid      (w_skid_valid),
    .o_payload    (w_skid_payload)
  );

  assign in_ready    = r_in_ready;
  assign out_valid   = w_main_valid;
  assign out_payload = w_main_payload;
  assign occupancy   = r_occupancy;

endmodule

// File: tb/tb_pipe_bundle_reg.sv
// Directed self-checking bench for pipe_bundle_reg with LANES=2, PW=128.
module tb_pipe_bundle_reg;

  localparam int LANES = 2;
  localparam int PW    = 128;

  logic                clk;
  logic                rst;
  logic                flush;
  logic [LANES-1:0]    kill;
  logic [LANES-1:0]    in_valid;
  logic [LANES*PW-1:0] in_payload;
  logic                in_ready;
  logic [LANES-1:0]    out_valid;
  logic [LANES*PW-1:0] out_payload;
  logic                out_ready;
  logic [1:0]          occupancy;

  int total;
  int bad;

  localparam logic [255:0] PA = {128'h0000_0000_0000_0000_0000_0000_0000_A1A1, 128'h0000_0000_0000_0000_0000_0000_0000_A0A0};
  localparam logic [255:0] PB = {128'h0000_0000_0000_0000_0000_0000_0000_B1B1, 128'h0000_0000_0000_0000_0000_0000_0000_B0B0};
  localparam logic [255:0] PC = {128'h0000_0000_0000_0000_0000_0000_0000_C1C1, 128'h0000_0000_0000_0000_0000_0000_0000_C0C0};

  pipe_bundle_reg #(.LANES(LANES), .PW(PW)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .kill        (kill),
    .in_valid    (in_valid),
    .in_payload  (in_payload),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_payload (out_payload),
    .out_ready   (out_ready),
    .occupancy   (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush = 1'b0; kill = 2'b00; in_valid = 2'b00; in_payload = 256'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1; out_ready = 1'b0; idle();
    tick(); tick();
    rst = 1'b0;
    total++;
    if ({out_valid, occupancy, in_ready} !== {2'b00, 2'd0, 1'b1} || out_payload !== 256'd0) begin
      bad++;
      $display("FAIL reset_state got v=%b occ=%0d rdy=%b pay=%h want v=00 occ=0 rdy=1 pay=0", out_valid, occupancy, in_ready, out_payload);
    end
  endtask

  task automatic test_stream();
    logic [255:0] seq [3];
    seq[0] = PA; seq[1] = PB; seq[2] = PC;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 2'b11; in_payload = seq[i];
      tick();
      total++;
      if ({out_valid, occupancy, in_ready} !== {2'b11, 2'd1, 1'b1} || out_payload !== seq[i]) begin
        bad++;
        $display("FAIL stream_%0d got v=%b occ=%0d rdy=%b pay=%h want v=11 occ=1 rdy=1 pay=%h", i, out_valid, occupancy, in_ready, out_payload, seq[i]);
      end
    end
    idle();
    tick();
    total++;
    if ({out_valid, occupancy, in_ready} !== {2'b00, 2'd0, 1'b1}) begin
      bad++;
      $display("FAIL stream_drain got v=%b occ=%0d rdy=%b want v=00 occ=0 rdy=1", out_valid, occupancy, in_ready);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid = 2'b11; in_payload = PA; tick();
    total++;
    if ({occupancy, in_ready} !== {2'd1, 1'b1} || out_payload !== PA) begin
      bad++;
      $display("FAIL bp_one got occ=%0d rdy=%b pay=%h want occ=1 rdy=1 pay=%h", occupancy, in_ready, out_payload, PA);
    end
    in_payload = PB; tick();
    total++;
    if ({occupancy, in_ready} !== {2'd2, 1'b0} || out_payload !== PA) begin
      bad++;
      $display("FAIL bp_two got occ=%0d rdy=%b pay=%h want occ=2 rdy=0 pay=%h", occupancy, in_ready, out_payload, PA);
    end
    in_payload = PC; tick();
    total++;
    if ({occupancy, in_ready} !== {2'd2, 1'b0} || out_payload !== PA) begin
      bad++;
      $display("FAIL bp_hold got occ=%0d rdy=%b pay=%h want occ=2 rdy=0 pay=%h", occupancy, in_ready, out_payload, PA);
    end
    out_ready = 1'b1; tick();
    total++;
    if ({out_valid, occupancy, in_ready} !== {2'b11, 2'd1, 1'b1} || out_payload !== PB) begin
      bad++;
      $display("FAIL bp_out_b got v=%b occ=%0d rdy=%b pay=%h want v=11 occ=1 rdy=1 pay=%h", out_valid, occupancy, in_ready, out_payload, PB);
    end
    tick();
    total++;
    if ({out_valid, occupancy} !== {2'b11, 2'd1} || out_payload !== PC) begin
      bad++;
      $display("FAIL bp_out_c got v=%b occ=%0d pay=%h want v=11 occ=1 pay=%h", out_valid, occupancy, out_payload, PC);
    end
    idle(); tick();
    total++;
    if ({out_valid, occupancy} !== {2'b00, 2'd0}) begin
      bad++;
      $display("FAIL bp_drain got v=%b occ=%0d want v=00 occ=0", out_valid, occupancy);
    end
  endtask

  task automatic test_kill_partial();
    out_ready = 1'b0;
    in_valid = 2'b11; in_payload = PA; tick();
    idle(); kill = 2'b10; tick();
    total++;
    if ({out_valid, occupancy} !== {2'b01, 2'd1} || out_payload !== {128'd0, PA[127:0]}) begin
      bad++;
      $display("FAIL kill_lane1 got v=%b occ=%0d pay=%h want v=01 occ=1 pay=%h", out_valid, occupancy, out_payload, {128'd0, PA[127:0]});
    end
    kill = 2'b01; tick();
    total++;
    if ({out_valid, occupancy, in_ready} !== {2'b00, 2'd0, 1'b1} || out_payload !== 256'd0) begin
      bad++;
      $display("FAIL kill_last_lane got v=%b occ=%0d rdy=%b pay=%h want v=00 occ=0 rdy=1 pay=0", out_valid, occupancy, in_ready, out_payload);
    end
    kill = 2'b00;
  endtask

  task automatic test_kill_with_consume();
    out_ready = 1'b1;
    in_valid = 2'b11; in_payload = PA; tick();
    in_payload = PB; kill = 2'b11; tick();
    total++;
    if ({out_valid, occupancy} !== {2'b11, 2'd1} || out_payload !== PB) begin
      bad++;
      $display("FAIL kill_ignored got v=%b occ=%0d pay=%h want v=11 occ=1 pay=%h", out_valid, occupancy, out_payload, PB);
    end
    idle(); tick();
  endtask

  task automatic test_kill_promote();
    out_ready = 1'b0;
    in_valid = 2'b11; in_payload = PA; tick();
    in_payload = PB; tick();
    idle(); kill = 2'b11; tick();
    total++;
    if ({out_valid, occupancy, in_ready} !== {2'b11, 2'd1, 1'b1} || out_payload !== PB) begin
      bad++;
      $display("FAIL kill_promote got v=%b occ=%0d rdy=%b pay=%h want v=11 occ=1 rdy=1 pay=%h", out_valid, occupancy, in_ready, out_payload, PB);
    end
    kill = 2'b00; out_ready = 1'b1; tick();
    total++;
    if ({out_valid, occupancy} !== {2'b00, 2'd0}) begin
      bad++;
      $display("FAIL promote_drain got v=%b occ=%0d want v=00 occ=0", out_valid, occupancy);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid = 2'b11; in_payload = PA; tick();
    in_payload = PB; tick();
    flush = 1'b1; in_payload = PC; out_ready = 1'b1; tick();
    total++;
    if ({out_valid, occupancy, in_ready} !== {2'b00, 2'd0, 1'b1} || out_payload !== 256'd0) begin
      bad++;
      $display("FAIL flush got v=%b occ=%0d rdy=%b pay=%h want v=00 occ=0 rdy=1 pay=0", out_valid, occupancy, in_ready, out_payload);
    end
    idle(); tick();
    total++;
    if ({out_valid, occupancy} !== {2'b00, 2'd0}) begin
      bad++;
      $display("FAIL flush_no_ghost got v=%b occ=%0d want v=00 occ=0", out_valid, occupancy);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_valid = 2'b11; in_payload = PA; tick();
    in_payload = PB; tick();
    rst = 1'b1; in_payload = PC; kill = 2'b01; out_ready = 1'b1; tick();
    total++;
    if ({out_valid, occupancy, in_ready} !== {2'b00, 2'd0, 1'b1} || out_payload !== 256'd0) begin
      bad++;
      $display("FAIL reset_mid got v=%b occ=%0d rdy=%b pay=%h want v=00 occ=0 rdy=1 pay=0", out_valid, occupancy, in_ready, out_payload);
    end
    rst = 1'b0; kill = 2'b00; out_ready = 1'b0;
    in_valid = 2'b01; in_payload = {{128{1'b1}}, 128'h0000_0000_0000_0000_0000_0000_0000_5A5A};
    tick();
    total++;
    if ({out_valid, occupancy} !== {2'b01, 2'd1} ||
        out_payload !== {128'd0, 128'h0000_0000_0000_0000_0000_0000_0000_5A5A}) begin
      bad++;
      $display("FAIL invalid_lane_zero got v=%b occ=%0d pay=%h want v=01 occ=1 lane1=0 lane0=5a5a", out_valid, occupancy, out_payload);
    end
    out_ready = 1'b1; idle(); tick();
    total++;
    if ({out_valid, occupancy} !== {2'b00, 2'd0}) begin
      bad++;
      $display("FAIL empty_offer got v=%b occ=%0d want v=00 occ=0", out_valid, occupancy);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_stream();
    test_backpressure();
    test_kill_partial();
    test_kill_with_consume();
    test_kill_promote();
    test_flush();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
